fft_out_reorder: RTL and testbench

// - Downstream stage of the FFT top: takes the serial 34-bit result stream (bit-reversed bin order)
//   and re-emits each 16-point frame in natural bin order over a valid/ready handshake.
// - Ping-pong buffer of two N-entry banks: one bank fills while the other drains.

---
 rtl/fft_out_reorder_pkg.sv | 49 ++++
 rtl/fft_reorder_bank.sv | 77 +++++++
 rtl/fft_out_reorder.sv | 144 ++++++++++++++
 tb/tb_fft_out_reorder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_out_reorder_pkg
// Shared constants and types for the FFT output reorder stage.
//   - FFT_DATA_W / FFT_N / FFT_LOG_N : default frame geometry
//   - bank_state_e                   : life cycle of one ping-pong bank
//   - bank_writable / bank_readable  : state decode helpers
//   - sat_inc16                      : saturating 16-bit increment
// -----------------------------------------------------------------------------
package fft_out_reorder_pkg;

  localparam int FFT_DATA_W = 34;
  localparam int FFT_N      = 16;
  localparam int FFT_LOG_N  = 4;
  localparam int DROP_CNT_W = 16;

  // A bank moves EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // A bank may take writes until it holds a complete frame.
  function automatic logic bank_writable(input bank_state_e s);
    case (s)
      BANK_EMPTY, BANK_FILLING: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  // A bank may be read once it holds a complete frame.
  function automatic logic bank_readable(input bank_state_e s);
    case (s)
      BANK_FULL, BANK_DRAINING: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc16(input logic [DROP_CNT_W-1:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// -----------------------------------------------------------------------------
// fft_reorder_bank
// One half of the ping-pong reorder buffer: an N x DATA_W flop array written
// at the bit-reversed position of the incoming sample count and read at the
// natural bin index, plus the bank life-cycle state.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (state only)
//   i_wr_en      : store i_wr_data this cycle (only issued while writable)
//   i_wr_cnt     : arrival index within the frame (natural count)
//   i_wr_data    : sample to store
//   i_rd_en      : current bin consumed this cycle (only issued while readable)
//   i_rd_cnt     : natural bin index presented on o_rd_data
//   o_rd_data    : combinational read of bin i_rd_cnt
//   o_state      : bank life-cycle state
// -----------------------------------------------------------------------------
module fft_reorder_bank
  import fft_out_reorder_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int LOG_N  = FFT_LOG_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [LOG_N-1:0]  i_wr_cnt,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [LOG_N-1:0]  i_rd_cnt,
  output logic [DATA_W-1:0] o_rd_data,
  output bank_state_e       o_state
);

  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

  logic [LOG_N-1:0]  w_wr_addr;
  logic [DATA_W-1:0] r_mem [N];
  bank_state_e       r_state;

  // Arrival k of a bit-reversed stream belongs at bin bitrev(k).
  for (genvar g = 0; g < LOG_N; g++) begin : g_bitrev
    assign w_wr_addr[g] = i_wr_cnt[LOG_N-1-g];
  end

  // Sample storage; contents need no reset since reads are gated by state.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[w_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_cnt];

  // Bank life cycle: the last write of a frame marks it FULL, the last read frees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BANK_EMPTY;
    end else begin
      case (r_state)
        BANK_EMPTY, BANK_FILLING: begin
          if (i_wr_en) begin
            r_state <= (i_wr_cnt == LAST_IDX) ? BANK_FULL : BANK_FILLING;
          end
        end
        BANK_FULL, BANK_DRAINING: begin
          if (i_rd_en) begin
            r_state <= (i_rd_cnt == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
          end
        end
        default: r_state <= BANK_EMPTY;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/fft_out_reorder.sv
// -----------------------------------------------------------------------------
// fft_out_reorder
// Reorders the serial FFT result stream (bit-reversed bin order) into natural
// bin order using two ping-pong banks: one fills while the other drains.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : in_data holds a sample
//   in_ready   : current write bank can take a sample
//   in_data    : sample {re[16:0], im[16:0]} in bit-reversed order
//   out_valid  : out_data holds a sample
//   out_ready  : consumer takes out_data
//   out_data   : sample in natural bin order (zero while out_valid is low)
//   out_last   : marks bin N-1 of each frame
//   ovf        : sticky, a sample was offered while in_ready was low
//   drop_cnt   : saturating count of dropped samples
// Configuration macro:
//   FFT_REORDER_STATS_EN : adds the drop_cnt port and its counter.
// -----------------------------------------------------------------------------
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int LOG_N  = FFT_LOG_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              ovf
`ifdef FFT_REORDER_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [LOG_N-1:0]  r_wr_cnt;
  logic [LOG_N-1:0]  r_rd_cnt;
  logic              r_ovf;

  bank_state_e       w_state   [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_drop;

  assign in_ready  = bank_writable(w_state[r_wr_bank]);
  assign out_valid = bank_readable(w_state[r_rd_bank]);
  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_drop    = in_valid && !in_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .DATA_W (DATA_W),
      .N      (N),
      .LOG_N  (LOG_N)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_fire && (r_wr_bank == 1'(b))),
      .i_wr_cnt  (r_wr_cnt),
      .i_wr_data (in_data),
      .i_rd_en   (w_rd_fire && (r_rd_bank == 1'(b))),
      .i_rd_cnt  (r_rd_cnt),
      .o_rd_data (w_rd_data[b]),
      .o_state   (w_state[b])
    );
  end

  // Hold out_data at zero while nothing is valid so reset and idle look clean.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = w_rd_data[r_rd_bank];
    end else begin
      out_data = '0;
    end
  end

  assign out_last = out_valid && (r_rd_cnt == LAST_IDX);

  // Write side: count arrivals and hand over to the other bank after a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_cnt <= r_wr_cnt + LOG_N'(1);
      if (r_wr_cnt == LAST_IDX) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Read side: walk bins in natural order and move on once the frame is drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_rd_fire) begin
      r_rd_cnt <= r_rd_cnt + LOG_N'(1);
      if (r_rd_cnt == LAST_IDX) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Overflow flag stays set until reset so software can see a drop happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

`ifdef FFT_REORDER_STATS_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Count every offered-but-refused sample, saturating rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_out_reorder
// Directed bench for fft_out_reorder. Inputs change 1 time unit after the
// rising edge; outputs are sampled in the same window, away from the edge.
// Frames are fed in bit-reversed order from a hand-written table so that the
// natural-order output is a simple ascending sequence.
// -----------------------------------------------------------------------------
module tb_fft_out_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic        out_last;
  logic        ovf;
`ifdef FFT_REORDER_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Bit-reversed arrival order for 16 points: arrival k carries bin BR[k].
  int BR [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf)
`ifdef FFT_REORDER_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_ovf"},       64'(ovf),       64'd0);
`ifdef FFT_REORDER_STATS_EN
    chk({tag, "_drop_cnt"},  64'(drop_cnt),  64'd0);
`endif
  endtask

  task automatic reset_dut();
    in_valid  = 1'b0;
    in_data   = 34'h0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();
  endtask

  // Feed one frame in bit-reversed order and check first out_valid latency.
  task automatic write_frame(input logic [33:0] base, input string tag);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_pre_valid"}, 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      in_data  = base + 34'(BR[k]);
      step();
    end
    in_valid = 1'b0;
    chk({tag, "_first_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic read_frame(input logic [33:0] base, input string tag);
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"},  64'(out_data),  64'(base + 34'(j)));
      chk({tag, "_last"},  64'(out_last),  64'(j == 15));
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int idx;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 34'h0;
    out_ready = 1'b0;
    #1;

    // 1: reset state, single frame, latency and ordering
    reset_dut();
    write_frame(34'h100, "t1w");
    read_frame(34'h100, "t1r");
    chk("t1_idle_valid", 64'(out_valid), 64'd0);

    // 2: three back-to-back frames with the consumer always ready
    reset_dut();
    out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (c < 48) begin
        chk("t2_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 34'h200 + 34'(16 * (c / 16)) + 34'(BR[c % 16]);
      end else begin
        in_valid = 1'b0;
      end
      chk("t2_out_valid", 64'(out_valid), 64'(c >= 16));
      if (c >= 16) begin
        chk("t2_out_data", 64'(out_data), 64'(34'h200 + 34'(c - 16)));
        chk("t2_out_last", 64'(out_last), 64'(((c - 16) % 16) == 15));
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t2_end_valid", 64'(out_valid), 64'd0);
    chk("t2_ovf", 64'(ovf), 64'd0);

    // 3: consumer stalled, 33 samples: the 33rd is refused
    reset_dut();
    for (int s = 0; s < 33; s++) begin
      chk("t3_in_ready", 64'(in_ready), 64'(s < 32));
      in_valid = 1'b1;
      in_data  = (s < 32) ? 34'h300 + 34'(16 * (s / 16)) + 34'(BR[s % 16]) : 34'h3FF;
      step();
    end
    in_valid = 1'b0;
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
`ifdef FFT_REORDER_STATS_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // 4: drain both banks with out_ready toggling every cycle
    idx = 0;
    for (int cyc = 0; cyc < 80 && idx < 32; cyc++) begin
      out_ready = ((cyc % 2) == 0);
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_data",  64'(out_data),  64'(34'h300 + 34'(idx)));
      chk("t4_last",  64'(out_last),  64'((idx % 16) == 15));
      step();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    chk("t4_drained", 64'(idx), 64'd32);
    chk("t4_end_valid", 64'(out_valid), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_ovf_sticky", 64'(ovf), 64'd1);

    // 5: reset after 7 writes and 3 reads, then a clean frame
    write_frame(34'h400, "t5a");
    for (int c = 0; c < 7; c++) begin
      in_valid  = 1'b1;
      in_data   = 34'h410 + 34'(BR[c]);
      out_ready = (c < 3);
      if (c < 3) chk("t5_pre_data", 64'(out_data), 64'(34'h400 + 34'(c)));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    step();
    rst = 1'b0;
    step();
    write_frame(34'h500, "t5w");
    read_frame(34'h500, "t5r");

    // 6: final read of bank 0 coincides with the 16th write to bank 1
    reset_dut();
    write_frame(34'h600, "t6c");
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_c_data", 64'(out_data), 64'(34'h600 + 34'(c)));
      in_valid = 1'b1;
      in_data  = 34'h610 + 34'(BR[c]);
      step();
    end
    chk("t6_bnd_valid", 64'(out_valid), 64'd1);
    chk("t6_bnd_data", 64'(out_data), 64'(34'h610));
    chk("t6_bnd_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 16; c++) begin
      chk("t6_d_data", 64'(out_data), 64'(34'h610 + 34'(c)));
      in_valid = 1'b1;
      in_data  = 34'h620 + 34'(BR[c]);
      step();
    end
    in_valid = 1'b0;
    read_frame(34'h620, "t6e");
    chk("t6_end_valid", 64'(out_valid), 64'd0);
    chk("t6_ovf", 64'(ovf), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
